// File: rtl/bfly_sdf_feed_if.sv
// Bus bundle for the R2SDF feed controller: input stream, butterfly
// operand/result exchange, and registered output stream.
interface bfly_sdf_feed_if #(
  parameter int WIDTH    = 12,
  parameter int NUM_PAIR = 16
);
  logic                               in_valid;
  logic [NUM_PAIR-1:0][WIDTH-1:0]     din_re;
  logic [NUM_PAIR-1:0][WIDTH-1:0]     din_im;
  logic                               flush;
  logic                               bfly_valid;
  logic [NUM_PAIR-1:0][WIDTH-1:0]     shift_data_re;
  logic [NUM_PAIR-1:0][WIDTH-1:0]     shift_data_im;
  logic [NUM_PAIR-1:0][WIDTH:0]       bfly_sum_re;
  logic [NUM_PAIR-1:0][WIDTH:0]       bfly_sum_im;
  logic [NUM_PAIR-1:0][WIDTH:0]       bfly_diff_re;
  logic [NUM_PAIR-1:0][WIDTH:0]       bfly_diff_im;
  logic [NUM_PAIR-1:0][WIDTH-1:0]     dout_re;
  logic [NUM_PAIR-1:0][WIDTH-1:0]     dout_im;
  logic                               dout_valid;
  logic                               busy;

  modport slave (
    input  in_valid, din_re, din_im, flush,
           bfly_sum_re, bfly_sum_im, bfly_diff_re, bfly_diff_im,
    output bfly_valid, shift_data_re, shift_data_im,
           dout_re, dout_im, dout_valid, busy
  );

  modport master (
    output in_valid, din_re, din_im, flush,
           bfly_sum_re, bfly_sum_im, bfly_diff_re, bfly_diff_im,
    input  bfly_valid, shift_data_re, shift_data_im,
           dout_re, dout_im, dout_valid, busy
  );
endinterface

// File: rtl/bfly_sdf_feed.sv
// Radix-2 single-path delay-feedback stage controller.
// First half-block is parked in the delay line; second half-block drives the
// butterfly against it, streaming sums out while differences go back into the
// delay line, to be streamed during the following first half (or a flush).
// Optional build macro SDF_SAT_EN: saturating WIDTH+1 -> WIDTH conversion at
// unity gain; without it the conversion is a floor halving (x >>> 1).

// Per-lane WIDTH+1 -> WIDTH conversion of butterfly sum and difference.
module bfly_sdf_lane #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH:0]   sum_re,
  input  logic [WIDTH:0]   sum_im,
  input  logic [WIDTH:0]   diff_re,
  input  logic [WIDTH:0]   diff_im,
  output logic [WIDTH-1:0] sum_re_f,
  output logic [WIDTH-1:0] sum_im_f,
  output logic [WIDTH-1:0] diff_re_f,
  output logic [WIDTH-1:0] diff_im_f
);
  function automatic logic [WIDTH-1:0] fmt(input logic [WIDTH:0] x);
`ifdef SDF_SAT_EN
    // top two bits disagree -> value outside the WIDTH-bit range
    if (x[WIDTH] != x[WIDTH-1])
      return x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return x[WIDTH-1:0];
`else
    return x[WIDTH:1];
`endif
  endfunction

  assign sum_re_f  = fmt(sum_re);
  assign sum_im_f  = fmt(sum_im);
  assign diff_re_f = fmt(diff_re);
  assign diff_im_f = fmt(diff_im);
endmodule

module bfly_sdf_feed #(
  parameter int WIDTH    = 12,
  parameter int NUM_PAIR = 16,
  parameter int DEPTH    = 16
) (
  input logic            clk,
  input logic            rstn,
  bfly_sdf_feed_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef logic [NUM_PAIR-1:0][WIDTH-1:0] vec_t;
  typedef enum logic [1:0] {FILL, COMPUTE, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic            have_diffs, have_nxt;
  logic            flush_take, drain, adv, wrap;

  vec_t mem_re [DEPTH];
  vec_t mem_im [DEPTH];
  vec_t sum_re_f, sum_im_f, diff_re_f, diff_im_f;
  vec_t dout_re, dout_im;
  logic dout_valid;

  for (genvar g = 0; g < NUM_PAIR; g++) begin : g_lane
    bfly_sdf_lane #(.WIDTH(WIDTH)) u_lane (
      .sum_re   (bus.bfly_sum_re[g]),
      .sum_im   (bus.bfly_sum_im[g]),
      .diff_re  (bus.bfly_diff_re[g]),
      .diff_im  (bus.bfly_diff_im[g]),
      .sum_re_f (sum_re_f[g]),
      .sum_im_f (sum_im_f[g]),
      .diff_re_f(diff_re_f[g]),
      .diff_im_f(diff_im_f[g])
    );
  end

  // flush only counts when there is a full block of differences to drain;
  // the accepting cycle already behaves like a drain cycle
  assign flush_take = (state == FILL) & have_diffs & bus.flush;
  assign drain      = (state == FLUSH) | flush_take;
  assign adv        = drain | bus.in_valid;
  assign wrap       = adv & (ptr == PW'(DEPTH-1));

  assign bus.bfly_valid    = (state == COMPUTE) & bus.in_valid;
  assign bus.shift_data_re = mem_re[ptr];
  assign bus.shift_data_im = mem_im[ptr];
  assign bus.dout_re       = dout_re;
  assign bus.dout_im       = dout_im;
  assign bus.dout_valid    = dout_valid;
  assign bus.busy          = (state != FILL) | have_diffs | (ptr != '0);

  // control state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= FILL;
      ptr        <= '0;
      have_diffs <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      have_diffs <= have_nxt;
    end
  end

  // next state: pointer advances on every effective strobe; phase flips on wrap
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    have_nxt  = have_diffs;
    if (adv) begin
      ptr_nxt = ptr + 1'b1;
      if (drain) begin
        state_nxt = wrap ? FILL : FLUSH;
        if (wrap) have_nxt = 1'b0;
      end else if (wrap) begin
        unique case (state)
          FILL:    begin state_nxt = COMPUTE; have_nxt = 1'b0; end
          COMPUTE: begin state_nxt = FILL;    have_nxt = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // delay line and registered output; read-before-write at the shared pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_re[i] <= '0;
        mem_im[i] <= '0;
      end
      dout_re    <= '0;
      dout_im    <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (adv) begin
        if (drain) begin
          dout_re    <= mem_re[ptr];
          dout_im    <= mem_im[ptr];
          dout_valid <= 1'b1;
        end else if (state == COMPUTE) begin
          mem_re[ptr] <= diff_re_f;
          mem_im[ptr] <= diff_im_f;
          dout_re     <= sum_re_f;
          dout_im     <= sum_im_f;
          dout_valid  <= 1'b1;
        end else begin
          mem_re[ptr] <= bus.din_re;
          mem_im[ptr] <= bus.din_im;
          dout_re     <= mem_re[ptr];
          dout_im     <= mem_im[ptr];
          dout_valid  <= have_diffs;
        end
      end
    end
  end
endmodule
